// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a small prefetch queue.
// Issues sequential fetches to a 1-cycle instruction SRAM. Returned {pc, inst}
// pairs are buffered in a DEPTH-entry circular FIFO and handed to ID over
// valid/ready. A flush or branch redirect discards queued and in-flight
// fetches. Flush takes priority over a branch.
module if_fetch_queue #(
    parameter int              DEPTH     = 4,
    parameter int              INST_W    = 32,
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = 32'hbfc0_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       br_e,
    input  logic [PC_W-1:0]            br_addr,
    input  logic                       flush,
    input  logic [PC_W-1:0]            flush_pc,
    output logic                       inst_sram_en,
    output logic [3:0]                 inst_sram_wen,
    output logic [PC_W-1:0]            inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic [INST_W-1:0]          inst_sram_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [INST_W-1:0]          out_inst,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_X  = (CNT_W + 1)'(DEPTH);

    logic [PC_W-1:0]   fetch_pc;
    logic [PC_W-1:0]   req_pc;
    logic              inflight;
    logic              drop;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];

    logic redirect;
    logic issue;
    logic push;
    logic pop;

    // Pointers wrap explicitly so non-power-of-2 depths stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Issue/return/pop decisions. The in-flight request is counted as a
    // reserved slot, and a same-cycle pop is not credited, so a push can
    // never land in a full queue.
    always_comb begin
        redirect  = flush | br_e;
        issue     = !rst && !redirect &&
                    (({1'b0, count} + {{CNT_W{1'b0}}, inflight}) < DEPTH_X);
        push      = !rst && !redirect && inflight && !drop;
        out_valid = !rst && !redirect && (count != '0);
        pop       = out_valid && out_ready;
    end

    assign inst_sram_en    = issue;
    assign inst_sram_wen   = 4'b0;
    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wdata = 32'b0;

    assign q_count  = count;
    assign out_pc   = (count != '0) ? mem_pc[rd_ptr]   : '0;
    assign out_inst = (count != '0) ? mem_inst[rd_ptr] : '0;

    // Fetch PC, in-flight tracking and queue bookkeeping; a redirect empties
    // the queue and retargets the fetch PC in one step.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_VEC;
            req_pc   <= '0;
            inflight <= 1'b0;
            drop     <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            // The response slot right after a redirect never carries live data.
            drop <= redirect;
            if (redirect) begin
                fetch_pc <= flush ? flush_pc : br_addr;
                inflight <= 1'b0;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    fetch_pc <= fetch_pc + PC_W'(4);
                    req_pc   <= fetch_pc;
                end
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue storage; contents past count are don't-care so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= req_pc;
            mem_inst[wr_ptr] <= inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: DEPTH=4 instance for the directed
// scenarios, DEPTH=3 instance for the randomised-ready wrap run.
module tb_if_fetch_queue;

    localparam logic [31:0] RV = 32'hbfc0_0000;
    localparam logic [31:0] KX = 32'h5a5a_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_e = 1'b0;
    logic [31:0] br_addr = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata = 32'hdead_beef;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  q_count;

    logic        en3;
    logic [3:0]  wen3;
    logic [31:0] addr3;
    logic [31:0] wdata3;
    logic [31:0] rdata3 = 32'hdead_beef;
    logic        out_valid3;
    logic        out_ready3 = 1'b0;
    logic [31:0] out_pc3;
    logic [31:0] out_inst3;
    logic [1:0]  q_count3;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_fetch_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .br_e(br_e), .br_addr(br_addr),
        .flush(flush), .flush_pc(flush_pc),
        .inst_sram_en(en), .inst_sram_wen(wen), .inst_sram_addr(addr),
        .inst_sram_wdata(wdata), .inst_sram_rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .q_count(q_count)
    );

    if_fetch_queue #(.DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .br_e(1'b0), .br_addr(32'h0),
        .flush(1'b0), .flush_pc(32'h0),
        .inst_sram_en(en3), .inst_sram_wen(wen3), .inst_sram_addr(addr3),
        .inst_sram_wdata(wdata3), .inst_sram_rdata(rdata3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_pc(out_pc3), .out_inst(out_inst3), .q_count(q_count3)
    );

    // 1-cycle SRAM models: data = addr ^ KX, garbage when not enabled.
    always @(posedge clk) begin
        rdata  <= en  ? (addr  ^ KX) : 32'hdead_beef;
        rdata3 <= en3 ? (addr3 ^ KX) : 32'hdead_beef;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_pc"}, out_pc, pc);
        check({tag, "_inst"}, out_inst, pc ^ KX);
    endtask

    logic [31:0] exp3;

    initial begin
        // Reset state and free run
        rst = 1'b1; out_ready = 1'b1;
        step(); step(); #1;
        check("rst_en", {31'b0, en}, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_count", {29'b0, q_count}, 32'd0);
        rst = 1'b0; #1;
        check("a_first_en", {31'b0, en}, 32'd1);
        check("a_first_addr", addr, RV);
        check("a_wen", {28'b0, wen}, 32'd0);
        check("a_wdata", wdata, 32'd0);
        step(); #1;
        check("a_c2_valid", {31'b0, out_valid}, 32'd0);
        check("a_c2_addr", addr, RV + 32'd4);
        for (int k = 0; k < 8; k++) begin
            step(); #1;
            check_head("a_run", RV + 32'(4 * k));
        end

        // Backpressure / full
        rst = 1'b1; out_ready = 1'b0;
        step(); rst = 1'b0;
        step(); step(); step(); step(); #1;
        check("b_c5_count", {29'b0, q_count}, 32'd3);
        check("b_c5_en", {31'b0, en}, 32'd0);
        step(); #1;
        check("b_c6_count", {29'b0, q_count}, 32'd4);
        check("b_c6_en", {31'b0, en}, 32'd0);
        check_head("b_c6_head", RV);
        step(); #1;
        check("b_c7_count", {29'b0, q_count}, 32'd4);
        check_head("b_c7_head", RV);
        step(); out_ready = 1'b1; #1;
        check("b_c8_en", {31'b0, en}, 32'd0);
        check_head("b_drain", RV);
        for (int k = 1; k < 8; k++) begin
            step(); #1;
            if (k == 1) check("b_resume_addr", addr, RV + 32'h10);
            check_head("b_drain", RV + 32'(4 * k));
        end

        // Branch with a fetch in flight and two entries queued
        rst = 1'b1; out_ready = 1'b0;
        step(); rst = 1'b0;
        step(); step(); step(); #1;
        check("c_c4_count", {29'b0, q_count}, 32'd2);
        br_e = 1'b1; br_addr = 32'hbfc0_0100; #1;
        check("c_br_en", {31'b0, en}, 32'd0);
        check("c_br_valid", {31'b0, out_valid}, 32'd0);
        step(); br_e = 1'b0; out_ready = 1'b1; #1;
        check("c_count0", {29'b0, q_count}, 32'd0);
        check("c_tgt_addr", addr, 32'hbfc0_0100);
        check("c_tgt_en", {31'b0, en}, 32'd1);
        step(); #1;
        check("c_c6_valid", {31'b0, out_valid}, 32'd0);
        step(); #1;
        check_head("c_tgt", 32'hbfc0_0100);
        step(); #1;
        check_head("c_tgt", 32'hbfc0_0104);
        step(); #1;
        check_head("c_tgt", 32'hbfc0_0108);

        // Simultaneous flush and branch: flush target wins
        flush = 1'b1; flush_pc = 32'hbfc0_0380;
        br_e = 1'b1; br_addr = 32'hbfc0_0200; #1;
        check("d_en", {31'b0, en}, 32'd0);
        check("d_valid", {31'b0, out_valid}, 32'd0);
        step(); flush = 1'b0; br_e = 1'b0; #1;
        check("d_count0", {29'b0, q_count}, 32'd0);
        check("d_addr", addr, 32'hbfc0_0380);
        step(); step(); #1;
        check_head("d_tgt", 32'hbfc0_0380);
        step(); #1;
        check_head("d_tgt", 32'hbfc0_0384);

        // Back-to-back branches: last one wins
        br_e = 1'b1; br_addr = 32'hbfc0_0500;
        step(); br_addr = 32'hbfc0_0600; #1;
        check("e_b2b_en", {31'b0, en}, 32'd0);
        step(); br_e = 1'b0; #1;
        check("e_b2b_addr", addr, 32'hbfc0_0600);
        step(); #1;
        check("e_b2b_gap", {31'b0, out_valid}, 32'd0);
        step(); #1;
        check_head("e_b2b", 32'hbfc0_0600);

        // Misaligned target is fetched unchanged
        br_e = 1'b1; br_addr = 32'hbfc0_0702;
        step(); br_e = 1'b0; #1;
        check("f_mis_addr", addr, 32'hbfc0_0702);
        step(); step(); #1;
        check_head("f_mis", 32'hbfc0_0702);
        step(); #1;
        check_head("f_mis", 32'hbfc0_0706);

        // Reset mid-operation: 3 queued + 1 in flight
        rst = 1'b1; out_ready = 1'b0;
        step(); rst = 1'b0;
        step(); step(); step(); step(); #1;
        check("g_pre_count", {29'b0, q_count}, 32'd3);
        rst = 1'b1; #1;
        check("g_rst_en", {31'b0, en}, 32'd0);
        check("g_rst_valid", {31'b0, out_valid}, 32'd0);
        step(); rst = 1'b0; out_ready = 1'b1; #1;
        check("g_count0", {29'b0, q_count}, 32'd0);
        check("g_valid0", {31'b0, out_valid}, 32'd0);
        check("g_addr", addr, RV);
        step(); #1;
        check("g_c2_valid", {31'b0, out_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(); #1;
            check_head("g_run", RV + 32'(4 * k));
        end

        // DEPTH=3 instance, random ready, pointer wrap
        rst = 1'b1;
        step(); rst = 1'b0;
        exp3 = RV;
        for (int k = 0; k < 1000; k++) begin
            out_ready3 = 1'($urandom_range(0, 1)); #1;
            if (out_valid3 && out_ready3) begin
                check("w_pc", out_pc3, exp3);
                check("w_inst", out_inst3, exp3 ^ KX);
                exp3 = exp3 + 32'd4;
            end
            check("w_count_le3", {31'b0, (q_count3 <= 2'd3)}, 32'd1);
            step();
        end
        check("w_progress", {31'b0, ((exp3 - RV) >> 2) > 32'd300}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
